// File: rtl/fanout_fork_buffer.sv
// Eager-fork broadcast buffer: each entry carries its own branch mask, and branches drain the head independently.
// The upstream ready is driven only from registered state and flush, never from out_ready.
module fanout_fork_buffer #(
    parameter int NUM_OUT    = 7,
    parameter int DATA_WIDTH = 17,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [NUM_OUT-1:0]           cfg_en,
    input  logic [NUM_OUT-1:0]           cfg_sel,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [NUM_OUT-1:0]           out_valid,
    input  logic [NUM_OUT-1:0]           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_WIDTH-1:0]         drop_count
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [NUM_OUT-1:0]    mask_q [DEPTH];
    logic [NUM_OUT-1:0]    mask_d [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;
    logic                  rdy_q;

    logic [NUM_OUT-1:0]    act, head_mask, hs, remain;
    logic                  not_empty, push_fire, push_store, push_drop, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign act        = cfg_en & cfg_sel;
    assign not_empty  = (occ_q != '0);
    assign head_mask  = mask_q[head_q];
    assign out_valid  = {NUM_OUT{not_empty}} & head_mask;
    assign out_data   = not_empty ? data_q[head_q] : last_q;
    assign hs         = out_valid & out_ready;
    assign remain     = head_mask & ~hs;
    assign pop        = not_empty && (remain == '0);

    // rdy_q keeps in_ready low while reset is held and until the first edge after release.
    assign in_ready   = rdy_q && (occ_q < OCC_W'(DEPTH)) && !flush;
    assign push_fire  = in_valid && in_ready;
    assign push_store = push_fire && (act != '0);
    assign push_drop  = push_fire && (act == '0);

    assign occupancy  = occ_q;
    assign drop_count = drop_q;

    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        drop_d = drop_q;
        last_d = last_q;

        if (not_empty) mask_d[head_q] = remain;
        if (pop) begin
            head_d = ptr_inc(head_q);
            last_d = data_q[head_q];
        end
        // tail never equals head while the head is live and there is room, so this write cannot clobber it.
        if (push_store) begin
            data_d[tail_q] = in_data;
            mask_d[tail_q] = act;
            tail_d         = ptr_inc(tail_q);
        end
        if (push_store && !pop)      occ_d = occ_q + 1'b1;
        else if (!push_store && pop) occ_d = occ_q - 1'b1;

        if (push_drop && (drop_q != '1)) drop_d = drop_q + 1'b1;

        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
            for (int i = 0; i < DEPTH; i++) mask_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            drop_q <= '0;
            last_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            drop_q <= drop_d;
            last_q <= last_d;
            rdy_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fanout_fork_buffer.sv
// Directed bench for fanout_fork_buffer: per-branch expected-token queues filled at push time,
// drained by a monitor that checks every branch handshake against the broadcast head token.
module tb_fanout_fork_buffer;

    localparam int N  = 7;
    localparam int DW = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [N-1:0]  cfg_en, cfg_sel, out_ready;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [N-1:0]  out_valid;
    logic [1:0]    occupancy;
    logic [15:0]   drop_count;

    logic          in_ready2;
    logic [DW-1:0] out_data2;
    logic [N-1:0]  out_valid2;
    logic [1:0]    occupancy2;
    logic [1:0]    drop_count2;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_drop = 0;
    logic [DW-1:0] exp_q [N][$];

    always #5 clk = ~clk;

    fanout_fork_buffer #(.NUM_OUT(N), .DATA_WIDTH(DW), .DEPTH(2), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy), .drop_count(drop_count)
    );

    // Narrow-counter variant sharing the same stimulus, used for the saturation check.
    fanout_fork_buffer #(.NUM_OUT(N), .DATA_WIDTH(DW), .DEPTH(2), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
        .occupancy(occupancy2), .drop_count(drop_count2)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] d);
        logic [N-1:0] a;
        a = cfg_en & cfg_sel;
        if (a == '0) exp_drop++;
        else for (int i = 0; i < N; i++) if (a[i]) exp_q[i].push_back(d);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < N; i++) exp_q[i].delete();
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < N; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) chk($sformatf("hs_unexpected_b%0d", i), 1, 0);
                    else chk($sformatf("data_b%0d", i), 32'(out_data), 32'(exp_q[i].pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        cfg_en = '0; cfg_sel = '0; out_ready = '0;

        // reset
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_drop", 32'(drop_count), 0);
        tick(); rst_n = 1'b1;
        @(negedge clk); chk("rdy_before_edge", 32'(in_ready), 0);
        tick(); @(negedge clk); chk("rdy_after_edge", 32'(in_ready), 1);

        // 1: three branches, all ready, back-to-back A,B,C
        cfg_en = '1; cfg_sel = 7'b0000111; out_ready = '1;
        tick(); in_valid = 1'b1; in_data = 17'h0A001;
        @(negedge clk); chk("t1_rdy", 32'(in_ready), 1); push_exp(17'h0A001);
        tick(); in_data = 17'h0B002;
        @(negedge clk); chk("t1_ov_a", 32'(out_valid), 32'h07); chk("t1_occ_a", 32'(occupancy), 1);
        push_exp(17'h0B002);
        tick(); in_data = 17'h1C003;
        @(negedge clk); chk("t1_ov_b", 32'(out_valid), 32'h07); chk("t1_occ_b", 32'(occupancy), 1);
        push_exp(17'h1C003);
        tick(); in_valid = 1'b0;
        @(negedge clk); chk("t1_ov_c", 32'(out_valid), 32'h07); chk("t1_occ_c", 32'(occupancy), 1);
        tick();
        @(negedge clk); chk("t1_ov_end", 32'(out_valid), 0); chk("t1_occ_end", 32'(occupancy), 0);
        chk("t1_drop", 32'(drop_count), 0);

        // 2: branch1 stalls three cycles; buffer fills
        cfg_sel = 7'b0000011; out_ready = 7'b1111101;
        tick(); in_valid = 1'b1; in_data = 17'h02A01;
        @(negedge clk); chk("t2_rdy0", 32'(in_ready), 1); push_exp(17'h02A01);
        tick(); in_data = 17'h02B02;
        @(negedge clk); chk("t2_ov1", 32'(out_valid), 32'h03); chk("t2_rdy1", 32'(in_ready), 1);
        push_exp(17'h02B02);
        tick(); in_data = 17'h02C03;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t2_ov_stall", 32'(out_valid), 32'h02);
            chk("t2_occ_full", 32'(occupancy), 2);
            chk("t2_rdy_full", 32'(in_ready), 0);
            if (k == 0) tick();
        end
        tick(); out_ready = '1;
        @(negedge clk); chk("t2_ov_rel", 32'(out_valid), 32'h02); chk("t2_rdy_rel", 32'(in_ready), 0);
        chk("t2_occ_rel", 32'(occupancy), 2);
        tick();
        @(negedge clk); chk("t2_rdy_c", 32'(in_ready), 1); chk("t2_occ_c", 32'(occupancy), 1);
        chk("t2_ov_b", 32'(out_valid), 32'h03); push_exp(17'h02C03);
        tick(); in_valid = 1'b0;
        @(negedge clk); chk("t2_occ_last", 32'(occupancy), 1);
        tick();
        @(negedge clk); chk("t2_occ_end", 32'(occupancy), 0);

        // 3: config change does not alter the stored mask
        out_ready = '0; cfg_sel = 7'b0000011;
        tick(); in_valid = 1'b1; in_data = 17'h03A01;
        @(negedge clk); push_exp(17'h03A01);
        tick(); cfg_sel = 7'b0000001; in_data = 17'h03B02;
        @(negedge clk); chk("t3_rdy", 32'(in_ready), 1); chk("t3_ov_a", 32'(out_valid), 32'h03);
        push_exp(17'h03B02);
        tick(); in_valid = 1'b0;
        @(negedge clk); chk("t3_occ", 32'(occupancy), 2); chk("t3_ov_hold", 32'(out_valid), 32'h03);
        tick(); out_ready = '1;
        @(negedge clk); chk("t3_ov_a2", 32'(out_valid), 32'h03);
        tick();
        @(negedge clk); chk("t3_ov_b", 32'(out_valid), 32'h01);
        tick();
        @(negedge clk); chk("t3_occ_end", 32'(occupancy), 0);

        // 4: all branches disabled, tokens dropped
        cfg_en = '0;
        for (int k = 0; k < 5; k++) begin
            tick(); in_valid = 1'b1; in_data = DW'(17'h04000 + k);
            @(negedge clk); chk("t4_rdy", 32'(in_ready), 1); chk("t4_ov", 32'(out_valid), 0);
            push_exp(in_data);
        end
        tick(); in_valid = 1'b0;
        @(negedge clk);
        chk("t4_drop", 32'(drop_count), 32'(exp_drop));
        chk("t4_drop_const", 32'(drop_count), 5);
        chk("t4_drop_sat", 32'(drop_count2), 3);
        chk("t4_occ", 32'(occupancy), 0);

        // 5: full buffer, pop and push offered in the same cycle
        cfg_en = '1; cfg_sel = 7'b0000011; out_ready = '0;
        tick(); in_valid = 1'b1; in_data = 17'h05E01;
        @(negedge clk); push_exp(17'h05E01);
        tick(); in_data = 17'h05F02;
        @(negedge clk); push_exp(17'h05F02);
        tick(); in_data = 17'h05003; out_ready = '1;
        @(negedge clk); chk("t5_rdy_full", 32'(in_ready), 0); chk("t5_occ2", 32'(occupancy), 2);
        tick(); out_ready = '0;
        @(negedge clk); chk("t5_rdy_next", 32'(in_ready), 1); chk("t5_occ1", 32'(occupancy), 1);
        push_exp(17'h05003);
        tick(); in_valid = 1'b0;
        @(negedge clk); chk("t5_occ2b", 32'(occupancy), 2);
        tick(); out_ready = '1;
        tick(); tick();
        @(negedge clk); chk("t5_occ_end", 32'(occupancy), 0);

        // 6: flush while full and half-consumed, then reset in the same situation
        out_ready = 7'b0000001;
        tick(); in_valid = 1'b1; in_data = 17'h06101;
        @(negedge clk); push_exp(17'h06101);
        tick(); in_data = 17'h06202;
        @(negedge clk); push_exp(17'h06202);
        tick(); in_valid = 1'b0; out_ready = '0;
        @(negedge clk); chk("t6_occ", 32'(occupancy), 2); chk("t6_ov_half", 32'(out_valid), 32'h02);
        tick(); flush = 1'b1; in_valid = 1'b1; in_data = 17'h06303;
        @(negedge clk); chk("t6_flush_rdy", 32'(in_ready), 0);
        tick(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk); chk("t6_flush_occ", 32'(occupancy), 0); chk("t6_flush_ov", 32'(out_valid), 0);
        chk("t6_flush_drop", 32'(drop_count), 32'(exp_drop));
        clear_exp();

        out_ready = 7'b0000001;
        tick(); in_valid = 1'b1; in_data = 17'h06404;
        @(negedge clk); push_exp(17'h06404);
        tick(); in_data = 17'h06505;
        @(negedge clk); push_exp(17'h06505);
        tick(); in_valid = 1'b0; out_ready = '0;
        @(negedge clk); chk("t6_occ_r", 32'(occupancy), 2); chk("t6_ov_half_r", 32'(out_valid), 32'h02);
        tick(); #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_occ", 32'(occupancy), 0);
        chk("t6_rst_ov", 32'(out_valid), 0);
        chk("t6_rst_drop", 32'(drop_count), 0);
        chk("t6_rst_rdy", 32'(in_ready), 0);
        clear_exp(); exp_drop = 0;
        tick(); rst_n = 1'b1;
        tick(); tick();
        @(negedge clk); chk("t6_post_ov", 32'(out_valid), 0); chk("t6_post_occ", 32'(occupancy), 0);
        chk("t6_post_rdy", 32'(in_ready), 1);

        // recovery push after reset
        out_ready = '1;
        tick(); in_valid = 1'b1; in_data = 17'h07707;
        @(negedge clk); push_exp(17'h07707);
        tick(); in_valid = 1'b0;
        @(negedge clk); chk("t7_ov", 32'(out_valid), 32'h03);
        tick(); tick();
        @(negedge clk); chk("t7_occ_end", 32'(occupancy), 0);
        begin
            int left;
            left = 0;
            for (int i = 0; i < N; i++) left += exp_q[i].size();
            chk("scoreboard_drained", 32'(left), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
